// File: rtl/ifetch_pkg.sv
// Shared widths, reset PC, FSM state and prefetch-entry payload for the fetch stage.
package ifetch_pkg;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BUF_DEPTH = 2;
    localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
    } buf_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry prefetch FIFO; the head always sits in slot 0 so it comes straight from a register.
module fetch_buf
    import ifetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic       i_flush,
    input  buf_entry_t i_din,
    output buf_entry_t o_head,
    output logic       o_full,
    output logic       o_empty,
    output logic [1:0] o_count
);

    buf_entry_t r_ent0;
    buf_entry_t r_ent1;
    logic [1:0] r_vld;
    logic       w_pop;

    assign w_pop = i_pop & r_vld[0];

    // Flush clears occupancy only; stale payload is don't-care once empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ent0 <= '0;
            r_ent1 <= '0;
            r_vld  <= 2'b00;
        end else if (i_flush) begin
            r_vld <= 2'b00;
        end else if (w_pop) begin
            if (r_vld[1]) begin
                r_ent0 <= r_ent1;
                if (i_push) begin
                    r_ent1 <= i_din;
                end else begin
                    r_vld <= 2'b01;
                end
            end else if (i_push) begin
                r_ent0 <= i_din;
            end else begin
                r_vld <= 2'b00;
            end
        end else if (i_push) begin
            if (!r_vld[0]) begin
                r_ent0 <= i_din;
                r_vld  <= 2'b01;
            end else if (!r_vld[1]) begin
                r_ent1 <= i_din;
                r_vld  <= 2'b11;
            end
        end
    end

    assign o_head  = r_ent0;
    assign o_full  = r_vld[1];
    assign o_empty = ~r_vld[0];
    assign o_count = 2'(r_vld[0]) + 2'(r_vld[1]);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, FETCH/HALT FSM, jump/flush priority, feeding a 2-entry prefetch buffer.
// Optional IFETCH_WRAP_HALT_EN: fetching from 8'hFF halts until a jump followed by halt=0.
module instr_fetch
    import ifetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              halt,
    output logic              halted
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              r_halted;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic              w_full;
    logic              w_empty;
    logic [1:0]        w_count;
    logic              w_locked;
    logic              w_lock_nxt;
    buf_entry_t        w_din;
    buf_entry_t        w_head;

`ifdef IFETCH_WRAP_HALT_EN
    logic r_wrap_lock;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrap_lock <= 1'b0;
        end else begin
            r_wrap_lock <= w_lock_nxt;
        end
    end

    assign w_locked = r_wrap_lock;
`else
    assign w_locked = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= FETCH;
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_halted <= (w_state_nxt == HALT);
        end
    end

    // Jump outranks everything: it flushes, blocks push/pop and only reloads the PC.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;
        w_flush     = jump_en;
        w_pop       = ~jump_en & instr_ready & (w_count != 2'd0);
        w_lock_nxt  = w_locked;

        case (r_state)
            FETCH:   if (halt) w_state_nxt = HALT;
            HALT:    if (!halt && !w_locked) w_state_nxt = FETCH;
            default: w_state_nxt = FETCH;
        endcase

        if (jump_en) begin
            w_pc_nxt   = jump_addr;
            w_lock_nxt = 1'b0;
        end else if (r_state == FETCH && !halt && (!w_full || w_pop)) begin
            w_push   = 1'b1;
            w_pc_nxt = r_pc + ADDR_W'(1);
`ifdef IFETCH_WRAP_HALT_EN
            if (r_pc == {ADDR_W{1'b1}}) begin
                w_state_nxt = HALT;
                w_lock_nxt  = 1'b1;
            end
`endif
        end
    end

    assign w_din.pc   = r_pc;
    assign w_din.data = rom_data;

    fetch_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_din   (w_din),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign rom_addr    = r_pc;
    assign instr_valid = ~w_empty;
    assign instr_data  = w_head.data;
    assign instr_pc    = w_head.pc;
    assign halted      = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: ROM byte = addr ^ 8'hA5, scoreboard queue of expected {pc, byte}.
module tb_instr_fetch;

    logic       clk;
    logic       rst;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_data;
    logic [7:0] instr_pc;
    logic       jump_en;
    logic [7:0] jump_addr;
    logic       halt;
    logic       halted;

    int total;
    int bad;
    logic [15:0] q[$];

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .halt        (halt),
        .halted      (halted)
    );

    assign rom_data = rom_addr ^ 8'hA5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ent(input logic [7:0] a);
        return {a, a ^ 8'hA5};
    endfunction

    task automatic push_range(input logic [7:0] start, input int n);
        for (int i = 0; i < n; i++) q.push_back(ent(8'(start + 8'(i))));
    endtask

    // Called at a negedge: drive ready, score any handshake that will fire, advance one cycle.
    task automatic step(input logic rdy);
        logic [15:0] e;
        instr_ready = rdy;
        if (instr_valid && rdy && !jump_en) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_entry got pc=%h data=%h, scoreboard empty", instr_pc, instr_data);
            end else begin
                e = q.pop_front();
                if ({instr_pc, instr_data} !== e) begin
                    bad++;
                    $display("FAIL pop got pc=%h data=%h, need pc=%h data=%h", instr_pc, instr_data, e[15:8], e[7:0]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input string name, output int gaps);
        int n;
        n = 0;
        gaps = 0;
        while (q.size() != 0 && n < 40) begin
            if (!instr_valid) gaps++;
            step(1'b1);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s_timeout got %0d left, need 0", name, q.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        jump_en = 1'b0;
        jump_addr = 8'h00;
        halt = 1'b0;
        instr_ready = 1'b0;
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        jump_en = 1'b0;
        jump_addr = 8'h00;
        halt = 1'b0;
        instr_ready = 1'b0;
        @(negedge clk);
        total++;
        if ({rom_addr, instr_valid, instr_data, instr_pc, halted} !== {8'h00, 1'b0, 8'h00, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL reset_vals got addr=%h v=%b d=%h pc=%h h=%b, need 00 0 00 00 0",
                     rom_addr, instr_valid, instr_data, instr_pc, halted);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({instr_valid, instr_pc, instr_data, rom_addr} !== {1'b1, 8'h00, 8'hA5, 8'h01}) begin
            bad++;
            $display("FAIL first_push got v=%b pc=%h d=%h addr=%h, need 1 00 a5 01",
                     instr_valid, instr_pc, instr_data, rom_addr);
        end
    endtask

    task automatic test_stream();
        int gaps;
        do_reset();
        push_range(8'h00, 16);
        drain("stream", gaps);
        total++;
        if (gaps != 0) begin
            bad++;
            $display("FAIL stream_gaps got %0d, need 0", gaps);
        end
    endtask

    task automatic test_backpressure();
        int gaps;
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0);
        total++;
        if ({rom_addr, instr_valid, instr_pc, instr_data} !== {8'h02, 1'b1, 8'h00, 8'hA5}) begin
            bad++;
            $display("FAIL full_hold got addr=%h v=%b pc=%h d=%h, need 02 1 00 a5",
                     rom_addr, instr_valid, instr_pc, instr_data);
        end
        push_range(8'h00, 8);
        drain("bp", gaps);
        total++;
        if (gaps != 0) begin
            bad++;
            $display("FAIL bp_gaps got %0d, need 0", gaps);
        end
    endtask

    task automatic test_jump();
        int gaps;
        do_reset();
        push_range(8'h00, 5);
        drain("prejump", gaps);
        total++;
        if (instr_pc !== 8'h05) begin
            bad++;
            $display("FAIL prejump_head got %h, need 05", instr_pc);
        end
        jump_en = 1'b1;
        jump_addr = 8'h40;
        q.delete();
        push_range(8'h40, 6);
        step(1'b1);
        jump_en = 1'b0;
        total++;
        if ({instr_valid, rom_addr} !== {1'b0, 8'h40}) begin
            bad++;
            $display("FAIL jump_flush got v=%b addr=%h, need 0 40", instr_valid, rom_addr);
        end
        step(1'b1);
        total++;
        if ({instr_valid, instr_pc, instr_data} !== {1'b1, 8'h40, 8'hE5}) begin
            bad++;
            $display("FAIL jump_first got v=%b pc=%h d=%h, need 1 40 e5", instr_valid, instr_pc, instr_data);
        end
        drain("postjump", gaps);
    endtask

    task automatic test_halt();
        int gaps;
        int n;
        do_reset();
        push_range(8'h00, 16);
        n = 0;
        while (rom_addr != 8'h0F && n < 40) begin
            step(1'b1);
            n++;
        end
        total++;
        if (rom_addr !== 8'h0F) begin
            bad++;
            $display("FAIL halt_approach got addr=%h, need 0f", rom_addr);
        end
        step(1'b0);
        halt = 1'b1;
        step(1'b0);
        total++;
        if ({halted, rom_addr, instr_valid, instr_pc} !== {1'b1, 8'h10, 1'b1, 8'h0E}) begin
            bad++;
            $display("FAIL halt_enter got h=%b addr=%h v=%b pc=%h, need 1 10 1 0e",
                     halted, rom_addr, instr_valid, instr_pc);
        end
        for (int i = 0; i < 4; i++) step(1'b1);
        total++;
        if ({halted, rom_addr, instr_valid, 32'(q.size())} !== {1'b1, 8'h10, 1'b0, 32'd0}) begin
            bad++;
            $display("FAIL halt_drain got h=%b addr=%h v=%b left=%0d, need 1 10 0 0",
                     halted, rom_addr, instr_valid, q.size());
        end
        halt = 1'b0;
        push_range(8'h10, 6);
        drain("resume", gaps);
        total++;
        if (halted !== 1'b0) begin
            bad++;
            $display("FAIL resume_halted got %b, need 0", halted);
        end
    endtask

    task automatic test_wrap();
        int gaps;
        do_reset();
        q.delete();
        jump_en = 1'b1;
        jump_addr = 8'hFE;
        step(1'b1);
        jump_en = 1'b0;
`ifdef IFETCH_WRAP_HALT_EN
        push_range(8'hFE, 2);
        drain("wrap", gaps);
        for (int i = 0; i < 4; i++) step(1'b1);
        total++;
        if ({halted, rom_addr, instr_valid} !== {1'b1, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL wrap_halt got h=%b addr=%h v=%b, need 1 00 0", halted, rom_addr, instr_valid);
        end
        jump_en = 1'b1;
        jump_addr = 8'h20;
        step(1'b1);
        jump_en = 1'b0;
        push_range(8'h20, 3);
        drain("wrap_resume", gaps);
`else
        push_range(8'hFE, 4);
        drain("wrap", gaps);
        total++;
        if (halted !== 1'b0) begin
            bad++;
            $display("FAIL wrap_halted got %b, need 0", halted);
        end
`endif
    endtask

    task automatic test_async_reset();
        int gaps;
        do_reset();
        push_range(8'h00, 6);
        drain("pre_rst", gaps);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({rom_addr, instr_valid, instr_data, instr_pc, halted} !== {8'h00, 1'b0, 8'h00, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL async_rst got addr=%h v=%b d=%h pc=%h h=%b, need 00 0 00 00 0",
                     rom_addr, instr_valid, instr_data, instr_pc, halted);
        end
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        push_range(8'h00, 8);
        drain("post_rst", gaps);
        total++;
        if (gaps != 0) begin
            bad++;
            $display("FAIL post_rst_gaps got %0d, need 0", gaps);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        instr_ready = 1'b0;
        jump_en = 1'b0;
        jump_addr = 8'h00;
        halt = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_jump();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
